// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register. A registered in_ready lets a
// stage accept one more entry than the downstream can absorb, so there is no
// combinational path from out_ready to in_ready. Control is cleared on flush
// and when the stage drains, while data is kept. A saturating counter records
// the cycles in which the downstream stalls.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
  logic [CNT_W-1:0]    w_stall_cnt_nxt;
  logic                w_accept;
  logic                w_emit;
  logic                w_stall;

  // Handshake qualifiers; flush discards the input but not a downstream take
  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_emit   = r_out_valid & out_ready;
  assign w_stall  = r_out_valid & ~out_ready & ~flush;

  // Next-state, datapath and stall-counter update
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_stall_cnt_nxt = r_stall_cnt;

    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_main_data_nxt = in_data;
          w_main_ctrl_nxt = in_ctrl;
          w_state_nxt     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          w_main_data_nxt = in_data;
          w_main_ctrl_nxt = in_ctrl;
        end else if (w_accept) begin
          w_skid_data_nxt = in_data;
          w_skid_ctrl_nxt = in_ctrl;
          w_state_nxt     = ST_FULL;
        end else if (w_emit) begin
          w_main_ctrl_nxt = '0;
          w_state_nxt     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_emit) begin
          w_main_data_nxt = r_skid_data;
          w_main_ctrl_nxt = r_skid_ctrl;
          w_state_nxt     = ST_ONE;
        end
      end
      default: begin
        w_main_ctrl_nxt = '0;
        w_skid_ctrl_nxt = '0;
        w_state_nxt     = ST_EMPTY;
      end
    endcase

    if (flush) begin
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
      w_state_nxt     = ST_EMPTY;
    end

    if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
  end

  // State, payload and counter registers; handshake flags follow next state
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a 2-deep FIFO model of the stage,
// directed scenarios followed by a long random run.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = 15;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              cpu_clk = 1'b0;
  logic              cpu_rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  ent_t        sb_q[$];
  int unsigned m_cnt;
  int          n_total;
  int          n_bad;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Count one comparison and report it if it differs
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model
  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (sb_q.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(sb_q[0].d));
      chk("out_ctrl", 64'(out_ctrl), 64'(sb_q[0].c));
    end else begin
      chk("out_ctrl_idle", 64'(out_ctrl), 64'd0);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl, input logic rst);
    int  sz;
    logic acc;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    cpu_rst   = rst;
    sz  = sb_q.size();
    acc = iv && (sz < 2) && !fl;
    if (rst) begin
      sb_q.delete();
      m_cnt = 0;
    end else begin
      if ((sz > 0) && !ordy && !fl && (m_cnt != CNT_MAX)) m_cnt++;
      if ((sz > 0) && ordy) sb_q.delete(0);
      if (fl) sb_q.delete();
      else if (acc) sb_q.push_back({c, d});
    end
    @(posedge cpu_clk);
    #1;
    check_outputs();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_cnt   = 0;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0; cpu_rst = 1'b1;
    #1;

    // Reset state
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hDEAD, 8'h5A, 1'b1, 1'b1, 1'b1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..4 with downstream always ready
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 8'(i), 1'b1, 1'b0, 1'b0);
    chk("stream_last", 64'(out_data), 64'd4);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: A, B held, C offered and refused, then drain in order
    cycle(1'b1, 32'h11, 8'h01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 32'h33, 8'h03, 1'b0, 1'b0, 1'b0);
    chk("bp_head_a", 64'(out_data), 64'h11);
    chk("bp_stall2", 64'(stall_cnt), 64'd2);
    cycle(1'b1, 32'h33, 8'h03, 1'b1, 1'b0, 1'b0);
    chk("bp_head_b", 64'(out_data), 64'h22);
    cycle(1'b1, 32'h33, 8'h03, 1'b1, 1'b0, 1'b0);
    chk("bp_head_c", 64'(out_data), 64'h33);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush while full with ctrl=0xFF and a new input offered
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'hA1, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA3, 8'hFF, 1'b0, 1'b1, 1'b0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("fl_no_leak", 64'(out_valid), 64'd0);

    // Saturation: one entry held, stalled for 20 cycles
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h77, 8'h07, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt", 64'(stall_cnt), 64'd15);

    // Reset mid-operation from FULL with seven stall cycles counted
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0A, 8'h0A, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0B, 8'h0B, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_cnt7", 64'(stall_cnt), 64'd7);
    cycle(1'b1, 32'h0C, 8'h0C, 1'b1, 1'b1, 1'b1);
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_data", 64'(out_data), 64'd0);
    chk("mid_cnt", 64'(stall_cnt), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    cycle(1'b1, 32'h0D, 8'h0D, 1'b0, 1'b0, 1'b0);
    chk("mid_accept", 64'(out_data), 64'h0D);

    // Random traffic against the FIFO model
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 32'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of the payload that is not cleared on flush.
REQ-002 The block SHALL have parameter CTRL_W, default 8: width of the control payload (write enables, selects), which is cleared on flush and on bubble.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-004 The block SHALL have port cpu_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port cpu_rst, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port flush, input, 1: kill all held entries.
REQ-007 The block SHALL have port in_valid, input, 1: upstream entry present.
REQ-008 The block SHALL have port in_ready, output, 1: the block can accept an entry this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_W: upstream payload.
REQ-010 The block SHALL have port in_ctrl, input, CTRL_W: upstream control.
REQ-011 The block SHALL have port out_valid, output, 1: downstream entry present.
REQ-012 The block SHALL have port out_ready, input, 1: downstream takes the entry this cycle.
REQ-013 The block SHALL have port out_data, output, DATA_W: head payload.
REQ-014 The block SHALL have port out_ctrl, output, CTRL_W: head control.
REQ-015 The block SHALL have port stall_cnt, output, CNT_W: count of downstream-stall cycles.

Function
REQ-016 The block SHALL hold two entries, main (drives out_*) and skid, and SHALL track occupancy as state EMPTY, ONE or FULL.
REQ-017 accept SHALL be in_valid & in_ready & ~flush, and emit SHALL be out_valid & out_ready.
REQ-018 in_ready SHALL be 1 exactly when the state is not FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-020 In EMPTY, accept SHALL load main from in_* and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-021 In ONE, accept&emit SHALL load main from in_* and stay in ONE (throughput 1 entry/cycle, latency 1 cycle).
REQ-022 In ONE, accept&~emit SHALL load skid from in_* and go to FULL, leaving main unchanged.
REQ-023 In ONE, ~accept&emit SHALL go to EMPTY and clear main ctrl to 0.
REQ-024 In ONE, ~accept&~emit SHALL hold all state.
REQ-025 In FULL, emit SHALL copy skid into main and go to ONE; ~emit SHALL hold all state.
REQ-026 flush SHALL take priority over all other events: the next state SHALL be EMPTY and main and skid ctrl SHALL be 0.
REQ-027 On flush, the data registers SHALL retain their values, any input presented that cycle SHALL be discarded, and an emit in the flush cycle SHALL still count as taken downstream.
REQ-028 out_ctrl SHALL be all-zero whenever out_valid is 0.
REQ-029 Entries SHALL leave in arrival order, with no loss and no duplication, under any out_ready pattern.
REQ-030 stall_cnt SHALL increment by 1 in every cycle with out_valid & ~out_ready & ~flush, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-031 stall_cnt SHALL be cleared only by cpu_rst.

Reset
REQ-032 While cpu_rst is 1 at a rising edge, the next state SHALL be EMPTY, and main and skid data and ctrl SHALL be 0.
REQ-033 While cpu_rst is 1 at a rising edge, stall_cnt SHALL be 0.
REQ-034 After reset, out_valid SHALL be 0, out_data 0, out_ctrl 0 and in_ready 1.
REQ-035 Reset SHALL override flush and all handshakes, and reset mid-operation SHALL drop both held entries.

Verification
REQ-036 Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid continuous, in_ready stays 1, stall_cnt=0.
REQ-037 Backpressure: feed A=0x11, B=0x22 with out_ready=0 -> state FULL, in_ready=0, C offered and not taken; then out_ready=1 -> outputs A, B, C in order, stall_cnt advanced once per stalled cycle.
REQ-038 Flush in FULL: two entries held, ctrl=0xFF, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, and the input is not seen at the output.
REQ-039 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds at 15.
REQ-040 Reset mid-operation: FULL with stall_cnt=7, then cpu_rst=1 for one edge -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1, and normal acceptance on the next cycle.
REQ-041 Random: random in_valid/out_ready/flush over 10k cycles against a 2-deep FIFO model -> order preserved, out_ctrl=0 whenever out_valid=0, never more than 2 entries held.
